// File: rtl/hamming_pkg.sv
// Hamming(15,11) shared definitions: codeword layout, types and encoder function.
// Used by both the batch encoder and the single-error-correcting decoder.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;

  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_P4 = 4;
  localparam int POS_P8 = 8;

  typedef logic [DATA_W-1:0] data11_t;
  typedef logic [CODE_W-1:0] code15_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAPT,
    ST_WR_LO,
    ST_WR_HI
  } state_t;

  // Bit i of the codeword holds position i+1; d1 is data bit 0.
  function automatic code15_t hamming_enc(input data11_t d);
    code15_t c;
    logic    p1;
    logic    p2;
    logic    p4;
    logic    p8;
    p8 = ^d[10:4];
    p4 = (^d[10:7]) ^ (^d[3:1]);
    p2 = d[10] ^ d[9] ^ d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    p1 = d[10] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
    c          = '0;
    c[14:8]    = d[10:4];
    c[6:4]     = d[3:1];
    c[2]       = d[0];
    c[POS_P8-1] = p8;
    c[POS_P4-1] = p4;
    c[POS_P2-1] = p2;
    c[POS_P1-1] = p1;
    return c;
  endfunction

endpackage

// File: rtl/hamming_enc_comb.sv
// Combinational Hamming(15,11) encoder around the shared package function.
// Kept separate so the batch FSM only deals with sequencing.
module hamming_enc_comb
  import hamming_pkg::*;
(
  input  data11_t i_data,
  output code15_t o_code
);

  assign o_code = hamming_enc(i_data);

endmodule

// File: rtl/hamming_enc_batch.sv
// Batch Hamming(15,11) encoder: reads NUM_WORDS data words from byte memory,
// writes each codeword back as two bytes, five cycles per word.
module hamming_enc_batch
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS = 15,
  parameter int RD_BASE   = 0,
  parameter int WR_BASE   = 30,
  parameter int ADDR_W    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             done,
  output logic                             busy,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [7:0]                       mem_rd_data,
  output logic                             mem_wr_en,
  output logic [7:0]                       mem_wr_data,
  output logic [$clog2(NUM_WORDS+1)-1:0]   word_idx
);

  localparam int IDX_W = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

  if (NUM_WORDS < 1) begin : g_bad_num_words
    $error("hamming_enc_batch: NUM_WORDS must be >= 1");
  end

  state_t     r_state;
  logic [7:0] r_lo;
  logic [2:0] r_hi;
  data11_t    w_data;
  code15_t    w_code;
  logic       w_unused;

  assign w_unused = ^mem_rd_data[7:3];

  // In CAPT the high bits are still on the bus, so encode from it directly.
  assign w_data = (r_state == ST_CAPT) ? {mem_rd_data[2:0], r_lo}
                                       : {r_hi, r_lo};

  hamming_enc_comb u_enc (
    .i_data (w_data),
    .o_code (w_code)
  );

  function automatic logic [ADDR_W-1:0] addr_of(
    input int               base,
    input logic [IDX_W-1:0] k,
    input logic             hi
  );
    return ADDR_W'(base + 2 * int'(k) + int'(hi));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      done        <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      word_idx    <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_RD_LO;
            done     <= 1'b0;
            busy     <= 1'b1;
            word_idx <= '0;
            mem_addr <= addr_of(RD_BASE, '0, 1'b0);
          end
        end
        ST_RD_LO: begin
          mem_addr <= addr_of(RD_BASE, word_idx, 1'b1);
          r_state  <= ST_RD_HI;
        end
        ST_RD_HI: begin
          r_lo    <= mem_rd_data;
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_hi        <= mem_rd_data[2:0];
          mem_wr_en   <= 1'b1;
          mem_addr    <= addr_of(WR_BASE, word_idx, 1'b0);
          mem_wr_data <= w_code[7:0];
          r_state     <= ST_WR_LO;
        end
        ST_WR_LO: begin
          mem_addr    <= addr_of(WR_BASE, word_idx, 1'b1);
          mem_wr_data <= {1'b0, w_code[14:8]};
          r_state     <= ST_WR_HI;
        end
        ST_WR_HI: begin
          mem_wr_en <= 1'b0;
          if (word_idx == LAST) begin
            r_state <= ST_IDLE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            word_idx <= word_idx + 1'b1;
            mem_addr <= addr_of(RD_BASE, word_idx + 1'b1, 1'b0);
            r_state  <= ST_RD_LO;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
